// File: rtl/pokey_chan_bank_if.sv
// Register-file-to-audio-datapath bundle: divider controls in, tones/mix/PWM out.
// Latency: none (wiring only).
// Backpressure: none; every signal is sampled or driven every clk179 cycle.
interface pokey_chan_bank_if #(
  parameter int NUM_CHN = 4,
  parameter int DIV_W   = 8
);
  localparam int MIX_W = 4 + $clog2(NUM_CHN);

  logic                     base_tick;
  logic                     restart;
  logic [NUM_CHN*DIV_W-1:0] audf;
  logic [NUM_CHN/2-1:0]     link;
  logic [NUM_CHN*4-1:0]     vol;
  logic [NUM_CHN-1:0]       vol_only;
  logic [NUM_CHN-1:0]       chn_en;
  logic [NUM_CHN-1:0]       tone;
  logic [NUM_CHN-1:0]       pulse;
  logic [MIX_W-1:0]         mix;
  logic                     pwm_out;

  // Register-file side: drives the controls, observes the audio results.
  modport master (
    output base_tick, restart, audf, link, vol, vol_only, chn_en,
    input  tone, pulse, mix, pwm_out
  );

  // Datapath side.
  modport slave (
    input  base_tick, restart, audf, link, vol, vol_only, chn_en,
    output tone, pulse, mix, pwm_out
  );
endinterface

// File: rtl/pokey_chan_bank.sv
// NUM_CHN-channel POKEY-style divider bank with volume mixer and 1-bit PWM DAC.
// Latency: tone/pulse 1 cycle after base_tick, mix 1 cycle after tone, pwm_out 1 cycle after pwm_cnt.
// Backpressure: none; free-running datapath, inputs are sampled every clk179 cycle.
module pokey_chan_bank #(
  parameter int NUM_CHN = 4,
  parameter int DIV_W   = 8
) (
  input  logic               clk179,
  input  logic               init_L,
  pokey_chan_bank_if.slave   bus
);
  localparam int MIX_W   = 4 + $clog2(NUM_CHN);
  localparam int PWM_MAX = NUM_CHN * 15;

  logic [DIV_W-1:0]   cnt_q [NUM_CHN];
  logic [DIV_W-1:0]   cnt_d [NUM_CHN];
  logic [NUM_CHN-1:0] tone_q, tone_d;
  logic [NUM_CHN-1:0] pulse_q, pulse_d;
  logic [2*DIV_W-1:0] pair_cnt;

  logic [MIX_W-1:0]   mix_q, mix_d;
  logic [MIX_W-1:0]   pwm_cnt_q;
  logic [MIX_W-1:0]   mix_hold_q;
  logic               pwm_out_q;
  logic               pwm_wrap;

  // Divider next state: restart reloads everything, otherwise step on base_tick,
  // treating a linked pair as one double-width counter owned by the odd channel.
  always_comb begin
    cnt_d    = cnt_q;
    tone_d   = tone_q;
    pulse_d  = '0;
    pair_cnt = '0;
    if (bus.restart) begin
      for (int i = 0; i < NUM_CHN; i++) begin
        cnt_d[i] = bus.audf[i*DIV_W +: DIV_W];
      end
      tone_d = '0;
    end else if (bus.base_tick) begin
      for (int k = 0; k < NUM_CHN/2; k++) begin
        if (bus.link[k]) begin
          pair_cnt = {cnt_q[2*k+1], cnt_q[2*k]};
          if (pair_cnt == '0) begin
            pair_cnt         = bus.audf[2*k*DIV_W +: 2*DIV_W];
            pulse_d[2*k+1]   = 1'b1;
            tone_d[2*k+1]    = ~tone_q[2*k+1];
          end else begin
            pair_cnt = pair_cnt - (2*DIV_W)'(1);
          end
          cnt_d[2*k]   = pair_cnt[DIV_W-1:0];
          cnt_d[2*k+1] = pair_cnt[2*DIV_W-1:DIV_W];
        end else begin
          for (int j = 2*k; j < 2*k+2; j++) begin
            if (cnt_q[j] == '0) begin
              cnt_d[j]   = bus.audf[j*DIV_W +: DIV_W];
              pulse_d[j] = 1'b1;
              tone_d[j]  = ~tone_q[j];
            end else begin
              cnt_d[j] = cnt_q[j] - DIV_W'(1);
            end
          end
        end
      end
    end
  end

  // Divider state registers.
  always_ff @(posedge clk179 or negedge init_L) begin
    if (!init_L) begin
      for (int i = 0; i < NUM_CHN; i++) begin
        cnt_q[i] <= '0;
      end
      tone_q  <= '0;
      pulse_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CHN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      tone_q  <= tone_d;
      pulse_q <= pulse_d;
    end
  end

  // Mixer: sum the volumes of every enabled channel whose tone (or vol_only) is high.
  // PWM_MAX fits in MIX_W, so the sum never wraps.
  always_comb begin
    mix_d = '0;
    for (int i = 0; i < NUM_CHN; i++) begin
      if (bus.chn_en[i] && (tone_q[i] || bus.vol_only[i])) begin
        mix_d = mix_d + MIX_W'(bus.vol[i*4 +: 4]);
      end
    end
  end

  // Mixer output register.
  always_ff @(posedge clk179 or negedge init_L) begin
    if (!init_L) begin
      mix_q <= '0;
    end else begin
      mix_q <= mix_d;
    end
  end

  assign pwm_wrap = (pwm_cnt_q == MIX_W'(PWM_MAX - 1));

  // PWM DAC: mix is captured only at the period boundary so the duty cycle never
  // changes mid-period; mix_hold == PWM_MAX yields a constant high output.
  always_ff @(posedge clk179 or negedge init_L) begin
    if (!init_L) begin
      pwm_cnt_q  <= '0;
      mix_hold_q <= '0;
      pwm_out_q  <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_wrap ? '0 : pwm_cnt_q + MIX_W'(1);
      if (pwm_wrap) begin
        mix_hold_q <= mix_q;
      end
      pwm_out_q <= (pwm_cnt_q < mix_hold_q);
    end
  end

  assign bus.tone    = tone_q;
  assign bus.pulse   = pulse_q;
  assign bus.mix     = mix_q;
  assign bus.pwm_out = pwm_out_q;

endmodule
